debug_uart_tx: RTL and testbench

DEBUG_UART_TX -- requirements
Module: debug_uart_tx

---
 rtl/debug_uart_pkg.sv | 23 ++
 rtl/uart_tx_byte.sv | 105 ++++++++++
 rtl/debug_uart_tx.sv | 92 +++++++++
 tb/tb_debug_uart_tx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/debug_uart_pkg.sv
// Shared types and constants for the debug snapshot UART transmitter.
// The state enum is used by the byte serializer and observed by the frame sequencer.
package debug_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int         FRAME_BYTES    = 10;
  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  // Frame checksum: XOR of the eight snapshot bytes (header excluded).
  function automatic logic [7:0] xor_bytes(input logic [63:0] w);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r ^= w[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with bit timer. A load accepted at the end of a stop bit
// starts the next start bit on the following cycle, so bytes run back-to-back.
module uart_tx_byte
  import debug_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_byte_end,
  output state_t     o_state,
  output logic       o_tx
);

  localparam int             TW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0]  TICK_MAX = TW'(CLKS_PER_BIT - 1);

  state_t        r_state, w_state_nx;
  logic [TW-1:0] r_tick,  w_tick_nx;
  logic [2:0]    r_bit,   w_bit_nx;
  logic [7:0]    r_shift, w_shift_nx;
  logic          r_tx,    w_tx_nx;
  logic          w_bit_end;

  assign w_bit_end  = (r_tick == TICK_MAX);
  assign o_byte_end = (r_state == STOP) && w_bit_end;
  assign o_ready    = (r_state == IDLE) || o_byte_end;
  assign o_state    = r_state;
  assign o_tx       = r_tx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_tick  <= w_tick_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_tx    <= w_tx_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_tx_nx    = r_tx;
    // Timer restarts on every bit boundary and stays parked while idle.
    w_tick_nx  = (r_state == IDLE || w_bit_end) ? '0 : r_tick + 1'b1;
    case (r_state)
      IDLE: begin
        w_tx_nx = 1'b1;
        if (i_load) begin
          w_state_nx = START;
          w_shift_nx = i_data;
          w_tx_nx    = 1'b0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nx = DATA;
          w_bit_nx   = '0;
          w_tx_nx    = r_shift[0];
          w_shift_nx = r_shift >> 1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit == 3'd7) begin
            w_state_nx = STOP;
            w_tx_nx    = 1'b1;
          end else begin
            w_bit_nx   = r_bit + 3'd1;
            w_tx_nx    = r_shift[0];
            w_shift_nx = r_shift >> 1;
          end
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (i_load) begin
            w_state_nx = START;
            w_shift_nx = i_data;
            w_tx_nx    = 1'b0;
          end else begin
            w_state_nx = IDLE;
            w_tx_nx    = 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_tx_nx    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/debug_uart_tx.sv
// Debug snapshot frame sender: HEADER, eight snapshot bytes MSB first, XOR checksum,
// streamed as one continuous 8N1 burst through uart_tx_byte.
module debug_uart_tx
  import debug_uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] HEADER       = DEFAULT_HEADER
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        trigger,
  input  logic [63:0] snapshot,
  output logic        tx_pin_out,
  output logic        busy,
  output logic        frame_done,
  output logic        dropped
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

  logic [63:0] r_snap;
  logic [3:0]  r_byte_idx;
  logic        r_busy, r_done, r_drop;

  state_t      w_state;
  logic        w_ready, w_byte_end, w_tx;
  logic        w_accept, w_last, w_load;
  logic [3:0]  w_next_idx;
  logic [7:0]  w_chk, w_next_byte;

  assign w_accept   = trigger && (w_state == IDLE);
  assign w_last     = w_byte_end && (r_byte_idx == LAST_IDX);
  assign w_load     = w_ready && (w_accept || (w_byte_end && !w_last));
  assign w_next_idx = w_accept ? 4'd0 : r_byte_idx + 4'd1;
  assign w_chk      = xor_bytes(r_snap);

  // The header never depends on r_snap, so it can be loaded on the capture edge.
  always_comb begin
    w_next_byte = HEADER;
    case (w_next_idx)
      4'd1:    w_next_byte = r_snap[63:56];
      4'd2:    w_next_byte = r_snap[55:48];
      4'd3:    w_next_byte = r_snap[47:40];
      4'd4:    w_next_byte = r_snap[39:32];
      4'd5:    w_next_byte = r_snap[31:24];
      4'd6:    w_next_byte = r_snap[23:16];
      4'd7:    w_next_byte = r_snap[15:8];
      4'd8:    w_next_byte = r_snap[7:0];
      4'd9:    w_next_byte = w_chk;
      default: w_next_byte = HEADER;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_snap     <= '0;
      r_byte_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_done <= w_last;
      r_drop <= trigger && (w_state != IDLE);
      if (w_accept) begin
        r_snap <= snapshot;
        r_busy <= 1'b1;
      end
      if (w_load) r_byte_idx <= w_next_idx;
      if (w_last) begin
        r_busy     <= 1'b0;
        r_byte_idx <= '0;
      end
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .i_clk      (CLK100MHZ),
    .i_rst      (reset),
    .i_load     (w_load),
    .i_data     (w_next_byte),
    .o_ready    (w_ready),
    .o_byte_end (w_byte_end),
    .o_state    (w_state),
    .o_tx       (w_tx)
  );

  assign tx_pin_out = w_tx;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign dropped    = r_drop;

endmodule

// File: tb/tb_debug_uart_tx.sv
// Directed bench for debug_uart_tx at 4 clocks per bit: decodes the serial line of
// each 400-cycle frame and checks handshake pulses around capture, drop and reset.
module tb_debug_uart_tx;

  localparam int CPB = 4;
  localparam int FRAME_CYC = 100 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trigger = 1'b0;
  logic [63:0] snapshot = '0;
  logic        tx, busy, done, drop;

  debug_uart_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
    .CLK100MHZ  (clk),
    .reset      (reset),
    .trigger    (trigger),
    .snapshot   (snapshot),
    .tx_pin_out (tx),
    .busy       (busy),
    .frame_done (done),
    .dropped    (drop)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic       txs [FRAME_CYC];
  logic       bsy [FRAME_CYC];
  int         n_busy, n_done, n_drop;
  logic [7:0] exp_b [10];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_exp(input logic [63:0] s, input logic [7:0] c);
    exp_b[0] = 8'hA5;
    for (int i = 0; i < 8; i++) exp_b[i+1] = s[63-8*i -: 8];
    exp_b[9] = c;
  endtask

  // Records one frame window (cycles 1..400 after the capture edge); act: 1 change
  // snapshot, 2 pulse trigger, 3 pulse reset, applied at cycle act_c.
  task automatic capture(input int act_c, input int act, input bit hold);
    n_busy = 0; n_done = 0; n_drop = 0;
    for (int c = 1; c <= FRAME_CYC; c++) begin
      @(negedge clk);
      txs[c-1] = tx;
      bsy[c-1] = busy;
      n_busy += int'(busy);
      n_done += int'(done);
      n_drop += int'(drop);
      if (c == 1 && !hold) trigger = 1'b0;
      if (c == act_c) begin
        case (act)
          1: snapshot = '1;
          2: trigger = 1'b1;
          3: reset = 1'b1;
          default: ;
        endcase
      end
      if (c == act_c + 1) begin
        if (act == 2) trigger = 1'b0;
        if (act == 3) reset = 1'b0;
      end
    end
  endtask

  function automatic logic [7:0] dec_byte(input int k);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[j] = txs[k*40 + (j+1)*4 + 1];
    return b;
  endfunction

  function automatic int line_errs(input int k);
    int e, base;
    e = 0;
    base = k * 40;
    for (int p = 0; p < 10; p++)
      for (int q = 1; q < CPB; q++)
        if (txs[base + p*CPB + q] !== txs[base + p*CPB]) e++;
    if (txs[base] !== 1'b0) e++;
    if (txs[base + 36] !== 1'b1) e++;
    return e;
  endfunction

  task automatic check_frame(input string tag);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("%s_byte%0d", tag, k), dec_byte(k), exp_b[k]);
      chk($sformatf("%s_line%0d", tag, k), line_errs(k), 0);
    end
    chk({tag, "_start_lat"}, txs[0], 1'b0);
    chk({tag, "_busy_rise"}, bsy[0], 1'b1);
    chk({tag, "_busy_cyc"}, n_busy, FRAME_CYC);
    chk({tag, "_done_early"}, n_done, 0);
  endtask

  task automatic post(input string tag);
    @(negedge clk);
    chk({tag, "_end_busy"}, busy, 1'b0);
    chk({tag, "_end_done"}, done, 1'b1);
    chk({tag, "_end_tx"}, tx, 1'b1);
    @(negedge clk);
    chk({tag, "_done_once"}, done, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held with trigger high: nothing may start
    reset = 1'b1; trigger = 1'b1; snapshot = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_drop", drop, 1'b0);
    reset = 1'b0; trigger = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_tx", tx, 1'b1);
    chk("idle_busy", busy, 1'b0);

    // basic frame
    snapshot = 64'h0123_4567_89AB_CDEF;
    set_exp(snapshot, 8'h00);
    trigger = 1'b1;
    capture(0, 0, 1'b0);
    check_frame("t1");
    post("t1");

    // snapshot changes 10 cycles into the frame
    snapshot = 64'h0000_0000_0000_00FF;
    set_exp(snapshot, 8'hFF);
    trigger = 1'b1;
    capture(10, 1, 1'b0);
    check_frame("t2");
    post("t2");

    // trigger while busy is dropped
    snapshot = 64'h8000_0000_0000_0001;
    set_exp(snapshot, 8'h81);
    trigger = 1'b1;
    capture(50, 2, 1'b0);
    check_frame("t3");
    chk("t3_drop_cnt", n_drop, 1);
    post("t3");
    repeat (10) @(negedge clk);
    chk("t3_no_refire", busy, 1'b0);
    chk("t3_idle_tx", tx, 1'b1);

    // trigger held high: back-to-back frames with a single mark cycle
    snapshot = 64'h1122_3344_5566_7788;
    set_exp(snapshot, 8'h88);
    trigger = 1'b1;
    capture(0, 0, 1'b1);
    check_frame("t4a");
    chk("t4_drop_cnt", n_drop, 399);
    snapshot = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    chk("t4_gap_tx", tx, 1'b1);
    chk("t4_gap_done", done, 1'b1);
    chk("t4_gap_busy", busy, 1'b0);
    set_exp(snapshot, 8'h00);
    capture(0, 0, 1'b0);
    check_frame("t4b");
    post("t4b");

    // reset mid-frame at cycle 123
    snapshot = 64'hDEAD_BEEF_CAFE_F00D;
    trigger = 1'b1;
    capture(123, 3, 1'b0);
    chk("t5_pre_busy", bsy[122], 1'b1);
    chk("t5_rst_tx", txs[123], 1'b1);
    chk("t5_rst_busy", bsy[123], 1'b0);
    chk("t5_busy_cyc", n_busy, 123);
    chk("t5_no_done", n_done, 0);
    @(negedge clk);
    chk("t5_no_done_end", done, 1'b0);
    chk("t5_idle_busy", busy, 1'b0);
    set_exp(snapshot, 8'hEB);
    trigger = 1'b1;
    capture(0, 0, 1'b0);
    check_frame("t5");
    post("t5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
